// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, character-length encodings,
// oversampling tick constants and the baud divisor table.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    // cfg_data_bits encodings
    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    localparam int         OS_DEFAULT   = 16;
    localparam logic [3:0] OS_MID_TICK  = 4'd7;
    localparam logic [3:0] OS_LAST_TICK = 4'd15;

    // 16x tick divisors from a 50 MHz clock
    localparam logic [15:0] BR_9600   = 16'd326;
    localparam logic [15:0] BR_19200  = 16'd163;
    localparam logic [15:0] BR_57600  = 16'd54;
    localparam logic [15:0] BR_115200 = 16'd27;

    // Index of the last data bit for a given character length (5..8 bits).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'd4 + {1'b0, data_bits};
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Received-character bus from the deframer to the RX FIFO / register block.
interface uart_rx_deframer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_parity_err;
    logic                  rx_frame_err;
    logic                  rx_busy;

    modport master (output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy);
    modport slave  (input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// rxd synchronizer chain (resets to the idle level) plus falling-edge detect
// on the synchronized line.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_prev;

    // NOTE: non-blocking (<=) on every flop so the chain moves exactly one
    // stage per clk regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: reset to 1 so the line looks idle and no phantom start edge appears.
            sync_q   <= '1;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign rxd_fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: qualifies the start bit, samples data/parity/stop at
// mid-bit on the 16x tick and delivers one character per frame with error flags.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = OS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_tick,
    input  logic                       rxd,
    input  logic [1:0]                 cfg_data_bits,
    input  logic                       cfg_parity_en,
    input  logic                       cfg_parity_odd,
    input  logic                       cfg_stop_bits,
    uart_rx_deframer_if.master         rx_if
);
    localparam int             TCW       = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] MID_TICK  = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);

    logic rxd_s;
    logic rxd_fall;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .rxd      (rxd),
        .rxd_s    (rxd_s),
        .rxd_fall (rxd_fall)
    );

    rx_state_t             state;
    logic [TCW-1:0]        tcnt;
    logic [2:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  perr_q;
    logic                  ferr_q;

    // frame configuration, frozen at start-edge detection
    logic [1:0]            data_bits_q;
    logic                  parity_en_q;
    logic                  parity_odd_q;
    logic                  stop2_q;

    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  rx_perr_q;
    logic                  rx_ferr_q;
    logic                  rx_busy_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the data path is reset too, so rx_data reads 0 after reset.
            state        <= ST_IDLE;
            tcnt         <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_bits_q  <= DB_8;
            parity_en_q  <= 1'b0;
            parity_odd_q <= 1'b0;
            stop2_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rxd_fall) begin
                        state        <= ST_START;
                        tcnt         <= '0;
                        shift_q      <= '0;
                        perr_q       <= 1'b0;
                        ferr_q       <= 1'b0;
                        data_bits_q  <= cfg_data_bits;
                        parity_en_q  <= cfg_parity_en;
                        parity_odd_q <= cfg_parity_odd;
                        stop2_q      <= cfg_stop_bits;
                        rx_busy_q    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (rx_tick) begin
                        if (tcnt == MID_TICK) begin
                            tcnt    <= '0;
                            bit_idx <= '0;
                            if (rxd_s) begin
                                // glitch, not a start bit
                                state     <= ST_IDLE;
                                rx_busy_q <= 1'b0;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_tick) begin
                        if (tcnt == LAST_TICK) begin
                            tcnt             <= '0;
                            shift_q[bit_idx] <= rxd_s;
                            bit_idx          <= bit_idx + 1'b1;
                            if (bit_idx == last_bit_idx(data_bits_q))
                                state <= parity_en_q ? ST_PARITY : ST_STOP1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (rx_tick) begin
                        if (tcnt == LAST_TICK) begin
                            tcnt   <= '0;
                            perr_q <= ((^shift_q) ^ rxd_s) != parity_odd_q;
                            state  <= ST_STOP1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                ST_STOP1, ST_STOP2: begin
                    if (rx_tick) begin
                        if (tcnt == LAST_TICK) begin
                            tcnt <= '0;
                            if (state == ST_STOP1 && stop2_q) begin
                                ferr_q <= ~rxd_s;
                                state  <= ST_STOP2;
                            end else begin
                                // deliver at mid stop bit so the next start edge is caught
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= shift_q;
                                rx_perr_q  <= perr_q;
                                rx_ferr_q  <= ferr_q | ~rxd_s;
                                rx_busy_q  <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_valid      = rx_valid_q;
    assign rx_if.rx_parity_err = rx_perr_q;
    assign rx_if.rx_frame_err  = rx_ferr_q;
    assign rx_if.rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus randomized
// frames, each compared against a frame-level reference model.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] cfg_data_bits = DB_8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop_bits = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_rx_deframer_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_deframer #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .rx_tick        (rx_tick),
        .rxd            (rxd),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop_bits  (cfg_stop_bits),
        .rx_if          (rx_if)
    );

    always #5 clk = ~clk;

    // 16x tick every 4 clks, held low while in reset
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            rx_tick = resetn;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t rxq[$];

    always @(negedge clk)
        if (rx_if.rx_valid)
            rxq.push_back('{d: rx_if.rx_data, pe: rx_if.rx_parity_err, fe: rx_if.rx_frame_err});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    function automatic logic [7:0] mask_d(input logic [7:0] d, input logic [1:0] db);
        logic [7:0] m;
        m = 8'hFF >> (2'd3 - db);
        return d & m;
    endfunction

    function automatic logic good_par(input logic [7:0] d, input logic [1:0] db, input logic odd);
        return (^mask_d(d, db)) ^ odd;
    endfunction

    // Serialize one frame; cfg is scrambled after the start edge to prove it was latched.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pen,
                              input logic podd, input logic st2, input logic pbit,
                              input logic s1, input logic s2, input logic idle_lvl, input int gap);
        cfg_data_bits  = db;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop_bits  = st2;
        rxd = 1'b0;
        ticks(2);
        {cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop_bits} = 5'($urandom);
        ticks(14);
        for (int i = 0; i < 5 + int'(db); i++) begin
            rxd = d[i];
            ticks(16);
        end
        if (pen) begin
            rxd = pbit;
            ticks(16);
        end
        rxd = s1;
        ticks(16);
        if (st2) begin
            rxd = s2;
            ticks(16);
        end
        rxd = idle_lvl;
        ticks(gap);
    endtask

    // Reference model: the character the receiver must deliver for the given line contents.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                                input logic pen, input logic podd, input logic st2,
                                input logic pbit, input logic s1, input logic s2);
        frame_t e, got;
        e.d  = mask_d(d, db);
        e.pe = pen && (((^e.d) ^ pbit) != podd);
        e.fe = !s1 || (st2 && !s2);
        check({tag, "_count"}, rxq.size(), 1);
        got = (rxq.size() > 0) ? rxq.pop_front() : '1;
        rxq = {};
        check({tag, "_data"}, got.d, e.d);
        check({tag, "_perr"}, got.pe, e.pe);
        check({tag, "_ferr"}, got.fe, e.fe);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, rx_if.rx_data, 0);
        check({tag, "_valid"}, rx_if.rx_valid, 0);
        check({tag, "_perr"}, rx_if.rx_parity_err, 0);
        check({tag, "_ferr"}, rx_if.rx_frame_err, 0);
        check({tag, "_busy"}, rx_if.rx_busy, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] db;
        logic       pen, podd, st2, pbit, s1, s2;
        int         gap;

        // reset state
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;
        ticks(4);

        // 8N1 0xA5
        send_frame(8'hA5, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        expect_frame("8n1_a5", 8'hA5, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("8n1_a5_busy_after", rx_if.rx_busy, 0);

        // 7E1 0x41, correct then wrong parity bit
        send_frame(8'h41, DB_7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        expect_frame("7e1_ok", 8'h41, DB_7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h41, DB_7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4);
        expect_frame("7e1_bad", 8'h41, DB_7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        ticks(20);
        check("perr_hold", rx_if.rx_parity_err, 1);

        // false start: low for 5 ticks only
        cfg_data_bits = DB_8; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
        rxd = 1'b0;
        ticks(2);
        check("false_start_busy", rx_if.rx_busy, 1);
        ticks(3);
        rxd = 1'b1;
        ticks(12);
        check("false_start_idle", rx_if.rx_busy, 0);
        check("false_start_novalid", rxq.size(), 0);
        send_frame(8'h33, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        expect_frame("after_false_33", 8'h33, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // stop bit low, then line held low
        send_frame(8'h3C, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        expect_frame("stop_low_3c", 8'h3C, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(40);
        check("held_low_noframe", rxq.size(), 0);
        check("held_low_busy", rx_if.rx_busy, 0);
        check("ferr_hold", rx_if.rx_frame_err, 1);
        rxd = 1'b1;
        ticks(4);

        // genuine break: line low through the whole frame and beyond
        cfg_data_bits = DB_8; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
        rxd = 1'b0;
        ticks(11 * 16);
        expect_frame("break", 8'h00, DB_8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(30);
        check("break_noframe", rxq.size(), 0);
        rxd = 1'b1;
        ticks(4);

        // 8O2 back to back, no idle gap
        send_frame(8'h00, DB_8, 1'b1, 1'b1, 1'b1, good_par(8'h00, DB_8, 1'b1), 1'b1, 1'b1, 1'b1, 0);
        expect_frame("8o2_00", 8'h00, DB_8, 1'b1, 1'b1, 1'b1, good_par(8'h00, DB_8, 1'b1), 1'b1, 1'b1);
        send_frame(8'hFF, DB_8, 1'b1, 1'b1, 1'b1, good_par(8'hFF, DB_8, 1'b1), 1'b1, 1'b1, 1'b1, 4);
        expect_frame("8o2_ff", 8'hFF, DB_8, 1'b1, 1'b1, 1'b1, good_par(8'hFF, DB_8, 1'b1), 1'b1, 1'b1);

        // reset pulse during data bit 3 of an 8N1 frame (0x5A)
        cfg_data_bits = DB_8; cfg_parity_en = 1'b0; cfg_stop_bits = 1'b0;
        d = 8'h5A;
        rxd = 1'b0;
        ticks(16);
        for (int i = 0; i < 3; i++) begin
            rxd = d[i];
            ticks(16);
        end
        rxd = d[3];
        ticks(8);
        resetn = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        resetn = 1'b1;
        rxd = 1'b1;
        ticks(40);
        check("mid_reset_novalid", rxq.size(), 0);
        check("mid_reset_idle", rx_if.rx_busy, 0);
        send_frame(8'h1A, DB_5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        expect_frame("5n1_1a", 8'h1A, DB_5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // randomized frames
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom);
            db   = 2'($urandom_range(0, 3));
            pen  = ($urandom_range(0, 1) == 1);
            podd = ($urandom_range(0, 1) == 1);
            st2  = ($urandom_range(0, 1) == 1);
            pbit = good_par(d, db, podd) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 4) != 0);
            s2   = ($urandom_range(0, 4) != 0);
            gap  = (st2 ? s2 : s1) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
            send_frame(d, db, pen, podd, st2, pbit, s1, s2, 1'b1, gap);
            expect_frame($sformatf("rand%0d", n), d, db, pen, podd, st2, pbit, s1, s2);
        end

        ticks(8);
        check("final_idle", rx_if.rx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
